core_fetch_queue: RTL
=====================

CORE_FETCH_QUEUE -- requirements
Module: core_fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue entry count; legal values are powers of two, 2 to 16.
REQ-002 clk_i  input  1  clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  reset; synchronous, active-high.
REQ-004 flush_i  input  1  discards all queued and in-flight instructions (branch/exception redirect).
REQ-005 in_valid_i  input  1  fetch side has an instruction this cycle.
REQ-006 in_ready_o  output  1  queue accepts an instruction this cycle.
REQ-007 in_instr_i  input  32  fetched instruction word.
REQ-008 in_pc_i  input  32  PC of the fetched instruction.
REQ-009 out_valid_o  output  1  instruction presented to decode.
REQ-010 out_ready_i  input  1  decode consumes the presented instruction.
REQ-011 out_instr_o  output  32  head instruction word.
REQ-012 out_pc_o  output  32  head PC.
REQ-013 out_is_branch_o  output  1  head opcode[6:0] == 7'b1100011.
REQ-014 out_is_jump_o  output  1  head opcode[6:0] == 7'b1101111 (JAL) or 7'b1100111 (JALR).
REQ-015 count_o  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 The block SHALL be a circular FIFO with read and write pointers of $clog2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-017 Push SHALL occur when in_valid_i && in_ready_o; pop SHALL occur when out_valid_o && out_ready_i.
REQ-018 in_ready_o SHALL equal (count_o != DEPTH); a full queue SHALL NOT accept a push even if a pop occurs in the same cycle.
REQ-019 Predecode bits SHALL be computed from in_instr_i at push and stored with the entry alongside instruction and PC.
REQ-020 Simultaneous push and pop SHALL leave count_o unchanged and advance both pointers.
REQ-021 out_valid_o SHALL equal (count_o != 0) && !flush_i; head outputs SHALL show the read-pointer entry.
REQ-022 When out_valid_o is low, out_instr_o, out_pc_o and the predecode bits SHALL be don't-care; a bench SHALL NOT check them.
REQ-023 Push-to-out_valid_o latency SHALL be 1 cycle, except as set out in REQ-031.
REQ-024 Head outputs SHALL stay stable while out_valid_o && !out_ready_i.
REQ-025 flush_i SHALL take priority over push and pop: on the next edge count_o, read and write pointers SHALL become 0, and any same-cycle push SHALL be dropped.
REQ-026 in_ready_o SHALL NOT depend on flush_i.
REQ-027 Pop on empty and push on full SHALL NOT occur by construction; pointers and count SHALL never leave range.

Reset
REQ-028 With rst_i high at a clock edge, count_o, read pointer and write pointer SHALL become 0.
REQ-029 After reset, out_valid_o SHALL be 0 and in_ready_o SHALL be 1; entry storage SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all entries, with the same effect as flush; rst_i SHALL take priority over flush_i, push and pop.

Configuration
REQ-031 Macro CORE_FETCH_QUEUE_BYPASS_EN, when defined, SHALL enable the empty-queue bypass:
- When count_o == 0 and in_valid_i is high, out_valid_o SHALL equal in_valid_i && !flush_i.
- Head outputs SHALL come combinationally from in_instr_i, in_pc_i and the predecode of in_instr_i.
- If out_ready_i is also high, the instruction SHALL be consumed without being written and count_o SHALL stay 0.
- Otherwise it SHALL be written as a normal push.
REQ-032 Without CORE_FETCH_QUEUE_BYPASS_EN, there SHALL be no combinational path from any in_* input to any out_* output; latency is per REQ-023.

Verification
REQ-033 Reset, then push instr 0x00000013 at PC 0x0 with out_ready_i=1 -> no bypass: out_valid_o=1 one cycle later with pc 0x0, then count_o returns to 0; bypass: out_valid_o=1 the same cycle and count_o stays 0.
REQ-034 DEPTH=4, out_ready_i=0, push 5 consecutive instructions at PCs 0x0..0x10 -> in_ready_o=0 after the 4th, count_o=4, 5th not accepted; then drain -> PCs 0x0,0x4,0x8,0xC in order.
REQ-035 Queue holds 2 entries; assert push and pop together for 10 cycles -> count_o stays 2, order preserved across pointer wrap.
REQ-036 Queue holds 3 entries; assert flush_i together with in_valid_i=1 -> out_valid_o=0 during flush; next cycle count_o=0 and the flushed-cycle instruction never appears.
REQ-037 Push 0x00000063 (BEQ) then 0x0000006F (JAL) then 0x00008067 (JALR) -> out_is_branch_o=1,0,0 and out_is_jump_o=0,1,1.
REQ-038 Queue holds 3 entries; assert rst_i and flush_i together, with push -> count_o=0 and in_ready_o=1 next cycle, out_valid_o=0.

Source files
------------

// File: rtl/core_fetch_queue.sv
// core_fetch_queue: circular instruction fetch queue between fetch and decode.
// Each entry holds the instruction word, its PC and two predecode bits
// (conditional branch, JAL/JALR jump) computed when the entry is pushed.
// flush_i drops everything queued plus any push in the same cycle. rst_i has
// the same effect and takes priority over flush_i.
// Optional feature: define CORE_FETCH_QUEUE_BYPASS_EN to forward an incoming
// instruction straight to decode while the queue is empty. The default build
// (macro undefined) has no combinational path from in_* to out_*.
module core_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [31:0]              in_pc_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [31:0]              out_instr_o,
    output logic [31:0]              out_pc_o,
    output logic                     out_is_branch_o,
    output logic                     out_is_jump_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        is_branch;
        logic        is_jump;
    } entry_t;

    // Build a queue entry with its predecode bits from the raw fetch data
    function automatic entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
        entry_t e;
        e.instr     = instr;
        e.pc        = pc;
        e.is_branch = (instr[6:0] == 7'b1100011);
        e.is_jump   = (instr[6:0] == 7'b1101111) || (instr[6:0] == 7'b1100111);
        return e;
    endfunction

    entry_t          mem [DEPTH];
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [CW-1:0]   count_q;

    entry_t          in_ent;
    entry_t          head_ent;
    logic            empty;
    logic            full;
    logic            byp;
    logic            push;
    logic            pop;

    assign in_ent     = predecode(in_instr_i, in_pc_i);
    assign empty      = (count_q == '0);
    assign full       = (count_q == CW'(DEPTH));
    // Readiness depends only on occupancy: a full queue refuses a push even
    // when a pop frees a slot in the same cycle.
    assign in_ready_o = !full;

`ifdef CORE_FETCH_QUEUE_BYPASS_EN
    assign byp = empty && in_valid_i;
`else
    assign byp = 1'b0;
`endif

    // Select the head: the read-pointer entry, or the incoming word in bypass
    always_comb begin
        head_ent    = mem[rd_ptr_q];
        out_valid_o = !empty && !flush_i;
        if (byp) begin
            head_ent    = in_ent;
            out_valid_o = in_valid_i && !flush_i;
        end
    end

    // A bypassed instruction consumed this cycle is never written
    assign pop  = out_valid_o && out_ready_i && !byp;
    assign push = in_valid_i && in_ready_o && !(byp && out_valid_o && out_ready_i);

    assign out_instr_o     = head_ent.instr;
    assign out_pc_o        = head_ent.pc;
    assign out_is_branch_o = head_ent.is_branch;
    assign out_is_jump_o   = head_ent.is_jump;
    assign count_o         = count_q;

    // Entry storage is not reset; a dropped push must not land in it
    always_ff @(posedge clk_i) begin
        if (push && !flush_i && !rst_i) begin
            mem[wr_ptr_q] <= in_ent;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

endmodule
